// File: rtl/chess_pkg.sv
// Shared chess definitions: piece encoding, FSM start state
// and the power-on board image used by the board register file.
package chess_pkg;

  typedef enum logic [2:0] {
    PT_EMPTY  = 3'd0,
    PT_PAWN   = 3'd1,
    PT_KNIGHT = 3'd2,
    PT_BISHOP = 3'd3,
    PT_ROOK   = 3'd4,
    PT_QUEEN  = 3'd5,
    PT_KING   = 3'd6
  } piece_t;

  localparam int COLOR_BIT = 3;
  localparam logic WHITE = 1'b0;
  localparam logic BLACK = 1'b1;

  localparam logic [3:0] EMPTY = 4'h0;
  localparam logic [3:0] WHITE_KING = {WHITE, PT_KING};
  localparam logic [3:0] BLACK_KING = {BLACK, PT_KING};

  localparam logic [2:0] ST_START = 3'b000;

  function automatic logic [3:0] mk_sq(
    input logic   color,
    input piece_t kind
  );
    return {color, kind};
  endfunction

  function automatic piece_t back_rank(input int col);
    piece_t p;
    case (col)
      0, 7:    p = PT_ROOK;
      1, 6:    p = PT_KNIGHT;
      2, 5:    p = PT_BISHOP;
      3:       p = PT_QUEEN;
      4:       p = PT_KING;
      default: p = PT_EMPTY;
    endcase
    return p;
  endfunction

  // Square i lives at [4i+3:4i], i = {col, row}
  function automatic logic [255:0] init_board();
    logic [255:0] b;
    b = '0;
    for (int c = 0; c < 8; c++) begin
      b[(c*8+0)*4 +: 4] = mk_sq(BLACK, back_rank(c));
      b[(c*8+1)*4 +: 4] = mk_sq(BLACK, PT_PAWN);
      b[(c*8+6)*4 +: 4] = mk_sq(WHITE, PT_PAWN);
      b[(c*8+7)*4 +: 4] = mk_sq(WHITE, back_rank(c));
    end
    return b;
  endfunction

  localparam logic [255:0] INIT_BOARD = init_board();

endpackage

// File: rtl/capture_fifo.sv
// Show-ahead log of captured pieces with sticky overflow.
// A full FIFO still accepts a push when a pop frees the head slot.
import chess_pkg::*;

module capture_fifo #(
  parameter int DEPTH = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_clear,
  input  logic       i_push,
  input  logic [3:0] i_data,
  input  logic       i_pop,
  output logic       o_valid,
  output logic [3:0] o_data,
  output logic       o_overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [3:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_count;
  logic          r_overflow;

  logic w_empty;
  logic w_full;
  logic w_do_pop;
  logic w_do_push;

  assign w_empty   = (r_count == '0);
  assign w_full    = (r_count == FULL_CNT);
  assign w_do_pop  = i_pop && !w_empty;
  assign w_do_push = i_push && (!w_full || w_do_pop);

  always_ff @(posedge clk) begin
    if (w_do_push && !i_clear)
      r_mem[r_wptr] <= i_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else if (i_clear) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_do_push)
        r_wptr <= r_wptr + 1'b1;
      if (w_do_pop)
        r_rptr <= r_rptr + 1'b1;
      if (w_do_push && !w_do_pop)
        r_count <= r_count + 1'b1;
      else if (w_do_pop && !w_do_push)
        r_count <= r_count - 1'b1;
      if (i_push && !w_do_push)
        r_overflow <= 1'b1;
    end
  end

  assign o_valid    = !w_empty;
  assign o_data     = w_empty ? EMPTY : r_mem[r_rptr];
  assign o_overflow = r_overflow;

endmodule

// File: rtl/board_memory.sv
// 64-square board register file with capture logging
// and king presence flags for the chess front end.
import chess_pkg::*;

module board_memory #(
  parameter int CAPTURE_LOG_DEPTH = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [10:0]  changePiece,
  input  logic [2:0]   currentState,
  output logic [255:0] entireBoard,
  output logic [1:0]   kingsPresent,
  output logic         capValid,
  output logic [3:0]   capData,
  input  logic         capPop,
  output logic         capOverflow
);

  logic [255:0] r_board;

  logic       w_reload;
  logic       w_we;
  logic [5:0] w_addr;
  logic [7:0] w_bit;
  logic [3:0] w_new;
  logic [3:0] w_old;
  logic       w_capture;
  logic [1:0] w_kings;

  assign w_reload = (currentState == ST_START);
  assign w_we     = changePiece[10];
  assign w_addr   = changePiece[5:0];
  assign w_new    = changePiece[9:6];
  assign w_bit    = {w_addr, 2'b00};
  assign w_old    = r_board[w_bit +: 4];

  // Clearing a source square or rewriting a square is not a capture
  assign w_capture = w_we && !w_reload &&
                     (w_old != EMPTY) &&
                     (w_new != EMPTY) &&
                     (w_new != w_old);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      r_board <= INIT_BOARD;
    else if (w_reload)
      r_board <= INIT_BOARD;
    else if (w_we)
      r_board[w_bit +: 4] <= w_new;
  end

  always_comb begin
    w_kings = 2'b00;
    for (int i = 0; i < 64; i++) begin
      if (r_board[i*4 +: 4] == WHITE_KING)
        w_kings[0] = 1'b1;
      if (r_board[i*4 +: 4] == BLACK_KING)
        w_kings[1] = 1'b1;
    end
  end

  capture_fifo #(
    .DEPTH(CAPTURE_LOG_DEPTH)
  ) u_cap_fifo (
    .clk        (clk),
    .rst_n      (reset),
    .i_clear    (w_reload),
    .i_push     (w_capture),
    .i_data     (w_old),
    .i_pop      (capPop),
    .o_valid    (capValid),
    .o_data     (capData),
    .o_overflow (capOverflow)
  );

  assign entireBoard  = r_board;
  assign kingsPresent = w_kings;

endmodule

// File: tb/tb_board_memory.sv
// Bench for board_memory: vector table against a behavioural
// board model with a capture scoreboard queue.
module tb_board_memory;

  localparam int DEPTH = 4;
  localparam logic [2:0] GAME = 3'b001;
  localparam logic [2:0] START = 3'b000;

  logic         clk;
  logic         rst_n;
  logic [10:0]  cp;
  logic [2:0]   st;
  logic [255:0] board;
  logic [1:0]   kings;
  logic         cvalid;
  logic [3:0]   cdata;
  logic         cpop;
  logic         covf;

  board_memory #(
    .CAPTURE_LOG_DEPTH(DEPTH)
  ) dut (
    .clk          (clk),
    .reset        (rst_n),
    .changePiece  (cp),
    .currentState (st),
    .entireBoard  (board),
    .kingsPresent (kings),
    .capValid     (cvalid),
    .capData      (cdata),
    .capPop       (cpop),
    .capOverflow  (covf)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [10:0] cp;
    logic        pop;
    logic [2:0]  st;
    int          n;
  } vec_t;

  vec_t       vecs[$];
  logic [3:0] m_sq [64];
  logic [3:0] sb_q [$];
  logic       m_ovf;
  int         checks;
  int         failures;

  function automatic logic [10:0] mk(
    input logic en, input logic [3:0] v, input int idx
  );
    logic [5:0] a;
    a = 6'(idx);
    return {en, v, a};
  endfunction

  function automatic vec_t vv(
    input logic [10:0] c, input logic p,
    input logic [2:0] s, input int n
  );
    vec_t r;
    r.cp = c; r.pop = p; r.st = s; r.n = n;
    return r;
  endfunction

  task automatic m_init();
    logic [3:0] blk [8];
    logic [3:0] wht [8];
    blk = '{4'hC, 4'hA, 4'hB, 4'hD, 4'hE, 4'hB, 4'hA, 4'hC};
    wht = '{4'h4, 4'h2, 4'h3, 4'h5, 4'h6, 4'h3, 4'h2, 4'h4};
    for (int i = 0; i < 64; i++) m_sq[i] = 4'h0;
    for (int c = 0; c < 8; c++) begin
      m_sq[c*8+0] = blk[c];
      m_sq[c*8+1] = 4'h9;
      m_sq[c*8+6] = 4'h1;
      m_sq[c*8+7] = wht[c];
    end
  endtask

  task automatic m_reset();
    m_init();
    sb_q.delete();
    m_ovf = 1'b0;
  endtask

  task automatic m_edge(
    input logic [10:0] c, input logic p, input logic [2:0] s
  );
    logic [3:0] o;
    logic [3:0] nv;
    int a;
    if (s == START) begin
      m_reset();
    end else begin
      a  = int'(c[5:0]);
      nv = c[9:6];
      o  = m_sq[a];
      if (p && sb_q.size() > 0) void'(sb_q.pop_front());
      if (c[10] && o != 0 && nv != 0 && nv != o) begin
        if (sb_q.size() < DEPTH) sb_q.push_back(o);
        else m_ovf = 1'b1;
      end
      if (c[10]) m_sq[a] = nv;
    end
  endtask

  function automatic logic [255:0] m_flat();
    logic [255:0] f;
    for (int i = 0; i < 64; i++) f[i*4 +: 4] = m_sq[i];
    return f;
  endfunction

  function automatic logic [1:0] m_kings();
    logic [1:0] k;
    k = 2'b00;
    for (int i = 0; i < 64; i++) begin
      if (m_sq[i] == 4'h6) k[0] = 1'b1;
      if (m_sq[i] == 4'hE) k[1] = 1'b1;
    end
    return k;
  endfunction

  task automatic chk(
    input string nm, input logic [255:0] act, input logic [255:0] exp
  );
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    logic [3:0] hd;
    hd = (sb_q.size() > 0) ? sb_q[0] : 4'h0;
    chk({tag, ".board"}, board, m_flat());
    chk({tag, ".kings"}, 256'(kings), 256'(m_kings()));
    chk({tag, ".capValid"}, 256'(cvalid), 256'(sb_q.size() > 0));
    chk({tag, ".capData"}, 256'(cdata), 256'(hd));
    chk({tag, ".capOverflow"}, 256'(covf), 256'(m_ovf));
  endtask

  task automatic step(
    input logic [10:0] c, input logic p, input logic [2:0] s,
    input string tag
  );
    cp = c; cpop = p; st = s;
    @(posedge clk);
    m_edge(c, p, s);
    #1;
    chk_all(tag);
  endtask

  initial begin
    logic [10:0] idle;
    checks = 0;
    failures = 0;
    idle = mk(1'b0, 4'h0, 0);
    rst_n = 1'b0;
    cp = idle; cpop = 1'b0; st = GAME;
    m_reset();
    #12;
    chk("rst.idx39", 256'(board[39*4 +: 4]), 256'(4'h6));
    chk("rst.idx38", 256'(board[38*4 +: 4]), 256'(4'h1));
    chk("rst.idx0", 256'(board[0 +: 4]), 256'(4'hC));
    chk("rst.idx32", 256'(board[32*4 +: 4]), 256'(4'hE));
    chk_all("rst");
    rst_n = 1'b1;

    vecs.push_back(vv(mk(1, 4'h1, 36), 0, GAME, 2));
    vecs.push_back(vv(mk(1, 4'h0, 38), 0, GAME, 2));
    vecs.push_back(vv(idle, 0, GAME, 1));
    vecs.push_back(vv(mk(1, 4'h5, 1), 0, GAME, 3));
    vecs.push_back(vv(idle, 1, GAME, 1));
    vecs.push_back(vv(mk(1, 4'h1, 32), 0, GAME, 1));
    vecs.push_back(vv(idle, 1, GAME, 1));
    vecs.push_back(vv(mk(1, 4'h1, 8), 0, GAME, 1));
    vecs.push_back(vv(mk(1, 4'h1, 16), 0, GAME, 1));
    vecs.push_back(vv(mk(1, 4'h1, 24), 0, GAME, 1));
    vecs.push_back(vv(mk(1, 4'h1, 7), 0, GAME, 1));
    vecs.push_back(vv(mk(1, 4'h1, 56), 0, GAME, 1));
    vecs.push_back(vv(idle, 1, GAME, 4));
    vecs.push_back(vv(idle, 1, GAME, 1));
    vecs.push_back(vv(mk(1, 4'h1, 15), 0, GAME, 1));
    vecs.push_back(vv(mk(1, 4'h1, 23), 0, GAME, 1));
    vecs.push_back(vv(mk(1, 4'h1, 31), 0, GAME, 1));
    vecs.push_back(vv(mk(1, 4'h1, 47), 0, GAME, 1));
    vecs.push_back(vv(mk(1, 4'h1, 63), 1, GAME, 1));
    vecs.push_back(vv(idle, 1, GAME, 4));
    vecs.push_back(vv(idle, 0, GAME, 1));
    vecs.push_back(vv(mk(1, 4'h3, 9), 1, GAME, 1));
    vecs.push_back(vv(mk(1, 4'h5, 10), 0, START, 2));
    vecs.push_back(vv(idle, 0, GAME, 1));

    for (int i = 0; i < vecs.size(); i++)
      for (int k = 0; k < vecs[i].n; k++)
        step(vecs[i].cp, vecs[i].pop, vecs[i].st,
             $sformatf("v%0d.%0d", i, k));

    step(mk(1, 4'h1, 32), 0, GAME, "kcap");
    chk("kcap.kings", 256'(kings), 256'(2'b01));
    chk("kcap.capData", 256'(cdata), 256'(4'hE));

    step(mk(1, 4'h5, 20), 0, GAME, "mid.w");
    chk("mid.idx20", 256'(board[20*4 +: 4]), 256'(4'h5));
    #2;
    rst_n = 1'b0;
    m_reset();
    #1;
    chk("mid.async", board, m_flat());
    chk("mid.async.kings", 256'(kings), 256'(2'b11));
    chk("mid.async.capValid", 256'(cvalid), 256'(1'b0));
    #2;
    rst_n = 1'b1;
    step(mk(1, 4'h5, 20), 0, GAME, "mid.again");
    chk("mid.again.idx20", 256'(board[20*4 +: 4]), 256'(4'h5));
    step(idle, 0, GAME, "end");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
